// File: rtl/seq_detect_param_if.sv
// Serial-stream bus for seq_detect_param.
//   in_valid, in   : qualified serial data bit (stream source -> detector)
//   pat_load, pat_in: runtime pattern load, MSB is the oldest bit
//   cnt_clr        : synchronous clear of the match counter
//   y              : match pulse (detector -> downstream control)
//   match_cnt      : saturating match count
//   pat            : current pattern register
// master = stream source / controller, slave = detector.
interface seq_detect_param_if #(
    parameter int unsigned PAT_W = 3,
    parameter int unsigned CNT_W = 8
);
    logic             in_valid;
    logic             in;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic             cnt_clr;
    logic             y;
    logic [CNT_W-1:0] match_cnt;
    logic [PAT_W-1:0] pat;

    modport master (
        output in_valid, in, pat_load, pat_in, cnt_clr,
        input  y, match_cnt, pat
    );

    modport slave (
        input  in_valid, in, pat_load, pat_in, cnt_clr,
        output y, match_cnt, pat
    );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial-bit sequence detector with runtime-loadable pattern,
// build-time Mealy/Moore output and overlapping/non-overlapping detection,
// plus a saturating match counter.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_detect_param_if.slave (in_valid, in, pat_load, pat_in,
//           cnt_clr in; y, match_cnt, pat out)
module seq_detect_param #(
    parameter int unsigned     PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b110,
    parameter int unsigned     MOORE   = 0,
    parameter int unsigned     OVERLAP = 1,
    parameter int unsigned     CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_detect_param_if.slave  bus
);
    // fill counts 0..PAT_W-1, so $clog2(PAT_W) bits are enough
    localparam int unsigned FILL_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0] hist;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0] pat_r;
    logic [CNT_W-1:0] cnt;
    logic             y_q;

    logic             accept;
    logic             m;
    logic [PAT_W-1:0] window;

    // The window is the full candidate pattern: stored history plus the
    // bit arriving this cycle. Its low PAT_W-1 bits are also the next
    // history, which avoids a negative slice when PAT_W == 2.
    always_comb begin
        window = {hist, bus.in};
        accept = bus.in_valid & ~bus.pat_load;
        m      = accept & (fill == FILL_MAX) & (window == pat_r);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist  <= '0;
            fill  <= '0;
            pat_r <= PATTERN;
        end else if (bus.pat_load) begin
            pat_r <= bus.pat_in;
            hist  <= '0;
            fill  <= '0;
        end else if (accept) begin
            if (m && (OVERLAP == 0)) begin
                hist <= '0;
                fill <= '0;
            end else begin
                hist <= window[PAT_W-2:0];
                if (fill != FILL_MAX) begin
                    fill <= fill + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            y_q <= 1'b0;
        end else begin
            y_q <= m;
            if (bus.cnt_clr) begin
                cnt <= '0;
            end else if (m && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.y         = (MOORE != 0) ? y_q : m;
    assign bus.match_cnt = cnt;
    assign bus.pat       = pat_r;
endmodule
